// File: rtl/logic_reduce_pipe.sv
// logic_reduce_pipe
//   Pipelined N-input bitwise reduction gate with valid/ready flow control.
//   Each accepted transaction reduces NIN words of WIDTH bits with the
//   function chosen by in_mode: OR, AND, XOR or NOR. The result travels
//   through STAGES stage registers and then an output register, so a
//   transaction accepted at edge t is presented after edge t+STAGES.
//   A stall (out_valid && !out_ready) freezes the whole pipe. Bubbles move
//   forward only when the whole pipe advances.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   in_data/in_mode hold a transaction
//   in_ready   pipe can accept this cycle (= !stall)
//   in_data    NIN packed words, word k = in_data[k*WIDTH +: WIDTH]
//   in_mode    00 OR, 01 AND, 10 XOR, 11 NOR
//   out_valid  out_data/out_mode hold a result
//   out_ready  downstream accepts this cycle
//   out_data   reduction result
//   out_mode   mode that produced out_data
//   out_count  completed output transfers, modulo 2^CNTW
module logic_reduce_pipe #(
    parameter int WIDTH  = 8,
    parameter int NIN    = 3,
    parameter int STAGES = 2,
    parameter int CNTW   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NIN*WIDTH-1:0] in_data,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           out_mode,
    output logic [CNTW-1:0]      out_count
);

    // Bitwise reduction of all words under the selected mode.
    function automatic logic [WIDTH-1:0] reduce_words(
        input logic [1:0]           mode,
        input logic [NIN*WIDTH-1:0] words
    );
        logic [WIDTH-1:0] r_or;
        logic [WIDTH-1:0] r_and;
        logic [WIDTH-1:0] r_xor;
        logic [WIDTH-1:0] res;
        r_or  = '0;
        r_and = '1;
        r_xor = '0;
        for (int k = 0; k < NIN; k++) begin
            r_or  = r_or  | words[k*WIDTH +: WIDTH];
            r_and = r_and & words[k*WIDTH +: WIDTH];
            r_xor = r_xor ^ words[k*WIDTH +: WIDTH];
        end
        case (mode)
            2'b00:   res = r_or;
            2'b01:   res = r_and;
            2'b10:   res = r_xor;
            default: res = ~r_or;
        endcase
        return res;
    endfunction

    logic                 vld_q  [STAGES];
    logic [WIDTH-1:0]     data_q [STAGES];
    logic [1:0]           mode_q [STAGES];
    logic                 out_vld_q;
    logic [WIDTH-1:0]     out_data_q;
    logic [1:0]           out_mode_q;
    logic [CNTW-1:0]      cnt_q;

    logic [WIDTH-1:0]     data_d;
    logic [CNTW-1:0]      cnt_d;
    logic                 stall;
    logic                 xfer;

    // The stall depends only on the output register and out_ready, so there
    // is no combinational path from in_valid to any output.
    assign stall    = out_vld_q && !out_ready;
    assign xfer     = out_vld_q && out_ready;
    assign in_ready = !stall;
    assign data_d   = reduce_words(in_mode, in_data);
    assign cnt_d    = cnt_q + CNTW'(1);

    // Stage registers plus output register: all advance together or all hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s]  <= 1'b0;
                data_q[s] <= '0;
                mode_q[s] <= 2'b00;
            end
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_mode_q <= 2'b00;
        end else if (!stall) begin
            vld_q[0]  <= in_valid;
            data_q[0] <= data_d;
            mode_q[0] <= in_mode;
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s]  <= vld_q[s-1];
                data_q[s] <= data_q[s-1];
                mode_q[s] <= mode_q[s-1];
            end
            out_vld_q  <= vld_q[STAGES-1];
            out_data_q <= data_q[STAGES-1];
            out_mode_q <= mode_q[STAGES-1];
        end
    end

    // Delivered-result counter, wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_logic_reduce_pipe.sv
module tb_logic_reduce_pipe;
    localparam int WIDTH  = 8;
    localparam int NIN    = 3;
    localparam int STAGES = 2;
    localparam int CNTW   = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [NIN*WIDTH-1:0] in_data;
    logic [1:0]           in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [1:0]           out_mode;
    logic [CNTW-1:0]      out_count;

    int n_pass  = 0;
    int n_total = 0;

    logic_reduce_pipe #(
        .WIDTH(WIDTH), .NIN(NIN), .STAGES(STAGES), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_mode(out_mode),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference reduction straight from the function definitions.
    function automatic logic [WIDTH-1:0] model_reduce(input logic [1:0] m, input logic [NIN*WIDTH-1:0] d);
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] r;
        r = (m == 2'b01) ? '1 : '0;
        for (int k = 0; k < NIN; k++) begin
            w = d[k*WIDTH +: WIDTH];
            case (m)
                2'b00:   r = r | w;
                2'b01:   r = r & w;
                2'b10:   r = r ^ w;
                default: r = r | w;
            endcase
        end
        return (m == 2'b11) ? ~r : r;
    endfunction

    // Model: a queue of in-flight transactions, each with the number of
    // advancing edges it has seen. A result is presented once it is oldest
    // and has advanced STAGES times.
    typedef struct {
        logic [WIDTH-1:0] d;
        logic [1:0]       m;
        int               age;
    } item_t;

    item_t           q[$];
    logic [CNTW-1:0] exp_cnt = '0;

    always @(posedge clk or posedge reset) begin : model
        bit ev;
        bit stl;
        item_t it;
        if (reset) begin
            q.delete();
            exp_cnt = '0;
        end else begin
            ev  = (q.size() > 0) && (q[0].age >= STAGES);
            stl = ev && !out_ready;
            if (ev && out_ready) begin
                void'(q.pop_front());
                exp_cnt = exp_cnt + 1'b1;
            end
            if (!stl) foreach (q[i]) q[i].age = q[i].age + 1;
            if (in_valid && !stl) begin
                it.d   = model_reduce(in_mode, in_data);
                it.m   = in_mode;
                it.age = 0;
                q.push_back(it);
            end
        end
    end

    always @(negedge clk) begin : compare
        bit ev;
        if (!reset) begin
            ev = (q.size() > 0) && (q[0].age >= STAGES);
            check("out_valid", 32'(out_valid), 32'(ev));
            check("in_ready", 32'(in_ready), 32'(!(ev && !out_ready)));
            check("out_count", 32'(out_count), 32'(exp_cnt));
            if (ev) begin
                check("out_data", 32'(out_data), 32'(q[0].d));
                check("out_mode", 32'(out_mode), 32'(q[0].m));
            end
        end
    end

    task automatic drive(input logic v, input logic [NIN*WIDTH-1:0] d, input logic [1:0] m);
        in_valid = v;
        in_data  = d;
        in_mode  = m;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 2'b00);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'b00;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_mode", 32'(out_mode), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single OR transaction, latency STAGES.
        drive(1'b1, {8'h01, 8'h10, 8'h80}, 2'b00);
        idle(1);
        check("t1_valid_early", 32'(out_valid), 32'd0);
        idle(1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h91);
        check("t1_mode", 32'(out_mode), 32'd0);
        idle(1);
        check("t1_count", 32'(out_count), 32'd1);

        // Back-to-back AND/XOR/NOR.
        drive(1'b1, {8'hFF, 8'h0F, 8'h3C}, 2'b01);
        drive(1'b1, {8'hFF, 8'h0F, 8'h3C}, 2'b10);
        drive(1'b1, {8'hFF, 8'h0F, 8'h3C}, 2'b11);
        check("t2_and", 32'(out_data), 32'h0C);
        idle(1);
        check("t2_xor", 32'(out_data), 32'hCC);
        idle(1);
        check("t2_nor", 32'(out_data), 32'h00);
        check("t2_nor_mode", 32'(out_mode), 32'd3);
        idle(1);
        check("t2_count", 32'(out_count), 32'd4);

        // Backpressure for 5 cycles with in_valid held high.
        drive(1'b1, {8'h01, 8'h10, 8'h80}, 2'b00);
        drive(1'b1, {8'hFF, 8'h0F, 8'h3C}, 2'b01);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, {8'hA5, 8'h5A, 8'h0F}, 2'b10);
            check("t3_in_ready", 32'(in_ready), 32'd0);
            check("t3_hold_data", 32'(out_data), 32'h91);
        end
        out_ready = 1'b1;
        idle(6);

        // Bubbles: one transaction every third cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, {8'(i * 17), 8'(8'hC3 ^ i), 8'h5A}, 2'(i));
            idle(2);
        end
        idle(3);

        // Asynchronous reset with results in flight.
        drive(1'b1, {8'h11, 8'h22, 8'h44}, 2'b00);
        drive(1'b1, {8'h11, 8'h22, 8'h44}, 2'b10);
        drive(1'b1, {8'h11, 8'h22, 8'h44}, 2'b11);
        #1;
        reset = 1'b1;
        #1;
        check("t5_valid_rst", 32'(out_valid), 32'd0);
        check("t5_count_rst", 32'(out_count), 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        idle(5);
        check("t5_no_stale", 32'(out_valid), 32'd0);

        // Counter wrap with CNTW=4.
        for (int i = 0; i < 16; i++) drive(1'b1, {8'(i), 8'hF0, 8'h0F}, 2'b10);
        idle(3);
        check("t6_wrap0", 32'(out_count), 32'd0);
        drive(1'b1, {8'h01, 8'h02, 8'h04}, 2'b00);
        idle(3);
        check("t6_wrap1", 32'(out_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
